// File: rtl/bus_datapath_n.sv
// Single-bus register-file datapath: one shared bus feeds the register file,
// the A operand latch and the G result latch, sequenced by a 4-state controller.
module bus_datapath_n #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [AW-1:0]     instr_rx,
    input  logic [AW-1:0]     instr_ry,
    input  logic [DATA_W-1:0] instr_imm,
    output logic              done,
    output logic              err,
    output logic              flag_c,
    output logic              flag_z,
    output logic [DATA_W-1:0] bus_mon,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [AW-1:0]       rx_q, ry_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   a_q, g_q;
    logic                gc_q;
    logic                flag_c_q, flag_z_q, done_q, err_q;
    logic [DATA_W-1:0]   bus;
    logic                is_alu;

    // Result in the low DATA_W bits; bit DATA_W is carry (ADD) or borrow (SUB).
    function automatic logic [DATA_W:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = {1'b0, a & b};
        endcase
        return r;
    endfunction

    assign is_alu = (op_q >= OP_ADD) && (op_q <= OP_AND);

    always_comb begin
        bus = '0;
        case (state_q)
            S_T1: begin
                if (op_q == OP_LOAD)     bus = imm_q;
                else if (op_q == OP_MOV) bus = regs_q[ry_q];
                else if (is_alu)         bus = regs_q[rx_q];
            end
            S_T2:    bus = regs_q[ry_q];
            S_T3:    bus = g_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_T1;
            S_T1:    state_d = is_alu ? S_T2 : S_IDLE;
            S_T2:    state_d = S_T3;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            g_q      <= '0;
            gc_q     <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= instr_op;
                        rx_q  <= instr_rx;
                        ry_q  <= instr_ry;
                        imm_q <= instr_imm;
                    end
                end
                S_T1: begin
                    if (op_q == OP_LOAD || op_q == OP_MOV) begin
                        regs_q[rx_q] <= bus;
                        done_q       <= 1'b1;
                    end else if (is_alu) begin
                        a_q <= bus;
                    end else begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end
                end
                S_T2: {gc_q, g_q} <= alu(op_q, a_q, bus);
                S_T3: begin
                    regs_q[rx_q] <= bus;
                    flag_c_q     <= gc_q;
                    flag_z_q     <= (g_q == '0);
                    done_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign flag_c      = flag_c_q;
    assign flag_z      = flag_z_q;
    assign bus_mon     = bus;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_bus_datapath_n.sv
// Directed bench for bus_datapath_n: instruction table with hand-computed
// results plus hand-written back-to-back, abort and reset-override sequences.
module tb_bus_datapath_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_rx, instr_ry;
    logic [7:0] instr_imm;
    logic       done, err, flag_c, flag_z;
    logic [7:0] bus_mon;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    bus_datapath_n #(.DATA_W(8), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rx(instr_rx), .instr_ry(instr_ry),
        .instr_imm(instr_imm),
        .done(done), .err(err), .flag_c(flag_c), .flag_z(flag_z),
        .bus_mon(bus_mon), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] imm;
        logic [7:0] exp_rx;
        logic       exp_c;
        logic       exp_z;
        logic       exp_err;
        int         lat;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        chk($sformatf("v%0d ready", idx), instr_ready, 1);
        dbg_addr    = v.rx;
        instr_valid = 1'b1;
        instr_op    = v.op;
        instr_rx    = v.rx;
        instr_ry    = v.ry;
        instr_imm   = v.imm;
        tick();
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        if (!done) begin
            chk($sformatf("v%0d done timeout", idx), 0, 1);
        end else begin
            chk($sformatf("v%0d latency", idx), lat, v.lat);
            chk($sformatf("v%0d err", idx), err, v.exp_err);
            chk($sformatf("v%0d R%0d", idx, v.rx), dbg_data, v.exp_rx);
            chk($sformatf("v%0d flag_c", idx), flag_c, v.exp_c);
            chk($sformatf("v%0d flag_z", idx), flag_z, v.exp_z);
        end
    endtask

    initial begin
        //        op    rx    ry    imm     exp_rx c  z  err lat
        tbl[0]  = '{3'd0, 3'd2, 3'd0, 8'h05, 8'h05, 0, 0, 0, 2};
        tbl[1]  = '{3'd0, 3'd1, 3'd0, 8'hF0, 8'hF0, 0, 0, 0, 2};
        tbl[2]  = '{3'd0, 3'd2, 3'd0, 8'h20, 8'h20, 0, 0, 0, 2};
        tbl[3]  = '{3'd2, 3'd1, 3'd2, 8'h00, 8'h10, 1, 0, 0, 4};
        tbl[4]  = '{3'd0, 3'd3, 3'd0, 8'h05, 8'h05, 1, 0, 0, 2};
        tbl[5]  = '{3'd3, 3'd3, 3'd3, 8'h00, 8'h00, 0, 1, 0, 4};
        tbl[6]  = '{3'd0, 3'd3, 3'd0, 8'h01, 8'h01, 0, 1, 0, 2};
        tbl[7]  = '{3'd0, 3'd4, 3'd0, 8'h02, 8'h02, 0, 1, 0, 2};
        tbl[8]  = '{3'd3, 3'd3, 3'd4, 8'h00, 8'hFF, 1, 0, 0, 4};
        tbl[9]  = '{3'd7, 3'd3, 3'd4, 8'h55, 8'hFF, 1, 0, 1, 2};
        tbl[10] = '{3'd4, 3'd3, 3'd4, 8'h00, 8'hFD, 0, 0, 0, 4};
        tbl[11] = '{3'd5, 3'd3, 3'd4, 8'h00, 8'h00, 0, 1, 0, 4};
        tbl[12] = '{3'd2, 3'd1, 3'd1, 8'h00, 8'h20, 0, 0, 0, 4};
        tbl[13] = '{3'd1, 3'd6, 3'd1, 8'h00, 8'h20, 0, 0, 0, 2};
        tbl[14] = '{3'd0, 3'd5, 3'd0, 8'h80, 8'h80, 0, 0, 0, 2};
        tbl[15] = '{3'd2, 3'd5, 3'd5, 8'h00, 8'h00, 1, 1, 0, 4};
        tbl[16] = '{3'd6, 3'd5, 3'd2, 8'hAA, 8'h00, 1, 1, 1, 2};

        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rx = '0;
        instr_ry = '0; instr_imm = '0; dbg_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst ready", instr_ready, 1);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst flag_c", flag_c, 0);
        chk("rst flag_z", flag_z, 0);
        chk("rst bus_mon", bus_mon, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1 chk($sformatf("rst R%0d", i), dbg_data, 0);
        end

        for (int i = 0; i < 17; i++) run_vec(i, tbl[i]);

        // Back-to-back: valid held high, MOV accepted in the LOAD done cycle
        tick();
        dbg_addr = 3'd2;
        instr_valid = 1'b1; instr_op = 3'd0; instr_rx = 3'd2; instr_ry = 3'd0; instr_imm = 8'h33;
        tick();
        instr_op = 3'd1; instr_rx = 3'd5; instr_ry = 3'd2; instr_imm = 8'h77;
        chk("b2b T1 ready", instr_ready, 0);
        tick();
        chk("b2b load done", done, 1);
        chk("b2b ready in done", instr_ready, 1);
        chk("b2b R2", dbg_data, 8'h33);
        tick();
        instr_valid = 1'b0;
        chk("b2b done pulse width", done, 0);
        chk("b2b mov T1 bus", bus_mon, 8'h33);
        tick();
        dbg_addr = 3'd5;
        #1;
        chk("b2b mov done", done, 1);
        chk("b2b R5", dbg_data, 8'h33);
        tick();
        chk("b2b idle", done, 0);
        chk("b2b no extra accept", instr_ready, 1);
        chk("idle bus_mon", bus_mon, 0);

        // Abort: XOR R1,R4 with rst during T2 (R1=0x20, R4=0x02)
        instr_valid = 1'b1; instr_op = 3'd4; instr_rx = 3'd1; instr_ry = 3'd4; instr_imm = 8'h00;
        tick();
        instr_valid = 1'b0;
        chk("abort T1 bus", bus_mon, 8'h20);
        tick();
        chk("abort T2 bus", bus_mon, 8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort ready", instr_ready, 1);
        chk("abort done", done, 0);
        chk("abort flag_c", flag_c, 0);
        chk("abort flag_z", flag_z, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1 chk($sformatf("abort R%0d", i), dbg_data, 0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("abort no done %0d", k), done, 0);
        end

        // rst overrides a simultaneous instr_valid
        dbg_addr = 3'd1;
        rst = 1'b1;
        instr_valid = 1'b1; instr_op = 3'd0; instr_rx = 3'd1; instr_imm = 8'hAA;
        tick();
        rst = 1'b0;
        instr_valid = 1'b0;
        chk("ovr ready", instr_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ovr no done %0d", k), done, 0);
        end
        chk("ovr R1", dbg_data, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_datapath_n.md
BUS_DATAPATH_N -- requirements
Module: bus_datapath_n

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data path and register width (>=2).
REQ-002 SHALL have parameter NREG, default 8, general register count (power of 2, >=2); AW = log2(NREG).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port instr_valid  in  1  instruction offered.
REQ-006 SHALL have port instr_ready  out  1  block can accept an instruction.
REQ-007 SHALL have port instr_op  in  3  opcode.
REQ-008 SHALL have port instr_rx  in  AW  destination / first source register.
REQ-009 SHALL have port instr_ry  in  AW  second source register.
REQ-010 SHALL have port instr_imm  in  DATA_W  immediate for LOAD.
REQ-011 SHALL have port done  out  1  one-cycle pulse, instruction complete.
REQ-012 SHALL have port err  out  1  one-cycle pulse with done, illegal opcode.
REQ-013 SHALL have port flag_c  out  1  carry (ADD) / borrow (SUB).
REQ-014 SHALL have port flag_z  out  1  last ALU result was zero.
REQ-015 SHALL have port bus_mon  out  DATA_W  internal bus value in the current cycle.
REQ-016 SHALL have port dbg_addr  in  AW  debug read select.
REQ-017 SHALL have port dbg_data  out  DATA_W  combinational read of R[dbg_addr].

Function
REQ-018 SHALL have opcodes 0 LOAD Rx<=imm; 1 MOV Rx<=Ry; 2 ADD Rx<=Rx+Ry; 3 SUB Rx<=Rx-Ry; 4 XOR; 5 AND; 6-7 illegal.
REQ-019 SHALL use FSM states IDLE, T1, T2, T3; instr_ready = (state==IDLE).
REQ-020 SHALL, in IDLE with instr_valid, latch op/rx/ry/imm and go to T1 on that edge; inputs are ignored outside IDLE.
REQ-021 SHALL, in T1 for LOAD, drive bus=imm, write Rx, and return to IDLE.
REQ-022 SHALL, in T1 for MOV, drive bus=R[ry], write Rx, and return to IDLE.
REQ-023 SHALL, for ALU ops: T1 bus=R[rx], A<=bus; T2 bus=R[ry], G<=A op bus; T3 bus=G, Rx<=bus, then IDLE.
REQ-024 SHALL, for an illegal opcode, write no register, leave flags unchanged, and return to IDLE from T1.
REQ-025 SHALL register done so it is high exactly one cycle, the cycle after the final write edge, with the new Rx visible on dbg_data.
REQ-026 SHALL raise err together with done only for illegal opcodes.
REQ-027 SHALL accept a new instruction in the same cycle done is high (back-to-back).
REQ-028 SHALL give accept-to-done latency: LOAD/MOV/illegal 2 cycles; ALU ops 4 cycles.
REQ-029 SHALL compute arithmetic modulo 2^DATA_W.
REQ-030 SHALL set flag_c to the carry-out for ADD and to borrow (Rx<Ry unsigned) for SUB, and clear it for XOR/AND.
REQ-031 SHALL set flag_z to (result==0) for ALU ops; LOAD/MOV leave both flags unchanged.
REQ-032 SHALL update flags on the T3 edge.
REQ-033 SHALL drive bus_mon to 0 in IDLE.
REQ-034 SHALL use the pre-instruction register values as operands when rx==ry (e.g. ADD R1,R1 doubles R1).

Reset
REQ-035 SHALL, with rst high, at the edge set all R[i], A, G, flags, done, err to 0 and state to IDLE.
REQ-036 SHALL treat rst mid-instruction as an abort: no write completes, no done pulse, instr_ready=1 the cycle after.
REQ-037 SHALL let rst override a simultaneous instr_valid (instruction dropped).

Verification
REQ-038 SHALL verify: reset, LOAD R2,0x05 -> done 2 cycles after accept, dbg_data(R2)=0x05, flags 0.
REQ-039 SHALL verify: R1=0xF0, R2=0x20, ADD R1,R2 -> R1=0x10, flag_c=1, flag_z=0, done 4 cycles after accept.
REQ-040 SHALL verify: R3=0x05, SUB R3,R3 -> R3=0x00, flag_z=1, flag_c=0; then SUB with R3=0x01, R4=0x02 -> R3=0xFF, flag_c=1.
REQ-041 SHALL verify: op=7 -> done and err high same cycle, no register or flag change.
REQ-042 SHALL verify: XOR accepted, rst asserted in T2 -> all registers 0, no done, instr_ready=1 next cycle.
REQ-043 SHALL verify: instr_valid held high with LOAD then MOV R5,R2 back-to-back -> second accepted in the done cycle, R5=R2.
